// File: rtl/operand_sequencer.sv
// operand_sequencer: collects four operands over independent valid/ready slots,
// issues a one-cycle start once all four are held, keeps the operand bus stable
// until the compute unit reports done, then frees the slots for the next set.
//
// Optional feature: define OPSEQ_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT
// cycles without done (sets the sticky err flag). Without it, WAIT waits forever
// and err is tied low.
module operand_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  input  logic               clear,
  output logic               start,
  output logic [4*WIDTH-1:0] ops,
  input  logic               done,
  output logic               busy,
  output logic [3:0]         captured,
  output logic               complete,
  output logic               err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // A timeout shorter than two cycles cannot be expressed by the wait counter.
  if (TIMEOUT < 2) begin : g_timeout_too_small
    $error("operand_sequencer: TIMEOUT must be >= 2");
  end

  state_t             state;
  state_t             state_next;
  logic [3:0]         captured_next;
  logic [4*WIDTH-1:0] ops_next;
  logic               start_next;
  logic               complete_next;
  logic [3:0]         accepted;
  logic               timeout_hit;

`ifdef OPSEQ_TIMEOUT_EN
  localparam int             CW        = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  // The TIMEOUT-th WAIT cycle without done aborts; done in that cycle still wins.
  always_comb begin
    timeout_hit = 1'b0;
    if ((state == WAIT) && !done && (wait_cnt == CNT_LAST)) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end
  end

  // Counter runs only through WAIT cycles without done; it sits at zero elsewhere,
  // so it is already cleared on every entry to WAIT.
  always_comb begin
    wait_cnt_next = CNT_ZERO;
    if ((state == WAIT) && !done && !timeout_hit) begin
      wait_cnt_next = wait_cnt + CNT_ONE;
    end else begin
      wait_cnt_next = CNT_ZERO;
    end
  end

  // Wait counter register.
  always_ff @(posedge clock) begin
    if (rst) begin
      wait_cnt <= CNT_ZERO;
    end else begin
      wait_cnt <= wait_cnt_next;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout_hit) begin
      err <= 1'b1;
    end
  end
`else
  // Without the timeout feature nothing can abort a WAIT.
  always_comb begin
    timeout_hit = 1'b0;
    err         = 1'b0;
  end
`endif

  // Slots are offered only in COLLECT, only while empty, and never while clear or reset.
  always_comb begin
    req_ready = 4'h0;
    if (rst || clear || (state != COLLECT)) begin
      req_ready = 4'h0;
    end else begin
      req_ready = ~captured;
    end
  end

  assign accepted = req_valid & req_ready;
  assign busy     = (state == ISSUE) || (state == WAIT);

  // Operand capture: accepted slots take new data, all other slots hold.
  always_comb begin
    ops_next = ops;
    for (int i = 0; i < 4; i++) begin
      if (accepted[i]) begin
        ops_next[i*WIDTH +: WIDTH] = req_data[i*WIDTH +: WIDTH];
      end else begin
        ops_next[i*WIDTH +: WIDTH] = ops[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state, slot flags and pulse outputs.
  always_comb begin
    state_next    = state;
    captured_next = captured;
    start_next    = 1'b0;
    complete_next = 1'b0;
    case (state)
      COLLECT: begin
        if (clear) begin
          captured_next = 4'h0;
          state_next    = COLLECT;
        end else begin
          captured_next = captured | accepted;
          if ((captured | accepted) == 4'hF) begin
            state_next = ISSUE;
            start_next = 1'b1;
          end else begin
            state_next = COLLECT;
          end
        end
      end
      ISSUE: begin
        // done is deliberately ignored here; the unit cannot finish before WAIT.
        state_next = WAIT;
      end
      WAIT: begin
        if (done) begin
          captured_next = 4'h0;
          state_next    = COLLECT;
          complete_next = 1'b1;
        end else if (timeout_hit) begin
          captured_next = 4'h0;
          state_next    = COLLECT;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        // Unreachable encoding: fall back to an empty COLLECT.
        captured_next = 4'h0;
        state_next    = COLLECT;
      end
    endcase
  end

  // State, operand and flag registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= COLLECT;
      captured <= 4'h0;
      ops      <= '0;
      start    <= 1'b0;
      complete <= 1'b0;
    end else begin
      state    <= state_next;
      captured <= captured_next;
      ops      <= ops_next;
      start    <= start_next;
      complete <= complete_next;
    end
  end

endmodule
